// File: rtl/instruction_decode_stage.sv
// Registered decode stage: splits instructions into RF read addresses and destination,
// with a valid/ready handshake, flush, and an optional load-use interlock (DECODE_INTERLOCK_EN).
module instruction_decode_stage #(
  parameter int IW  = 20,
  parameter int OPW = 4,
  parameter int RAW = 4,
  parameter logic [OPW-1:0] STORE_OP = 4'b1100,
  parameter logic [OPW-1:0] LOAD_OP  = 4'b1011
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  instruction,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_opcode,
  output logic [RAW-1:0] ReadAddressRF1,
  output logic [RAW-1:0] ReadAddressRF2,
  output logic [RAW-1:0] out_dest,
  output logic           out_we,
  output logic [7:0]     stall_count
);

  typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

  state_t state;

  logic [OPW-1:0] dec_op;
  logic [RAW-1:0] fld_a, fld_b, fld_c;
  logic [RAW-1:0] dec_rs1, dec_rs2, dec_dest;
  logic           dec_we;
  logic           drain, slot_free, hazard, accept, bubble;

  generate
    if (IW < OPW + 3*RAW) begin : g_bad_width
      $error("instruction_decode_stage: IW must be at least OPW + 3*RAW");
    end
    if (IW > OPW + 3*RAW) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^instruction[IW-OPW-3*RAW-1:0];
    end
  endgenerate

  assign dec_op = instruction[IW-1 -: OPW];
  assign fld_a  = instruction[IW-OPW-1 -: RAW];
  assign fld_b  = instruction[IW-OPW-RAW-1 -: RAW];
  assign fld_c  = instruction[IW-OPW-2*RAW-1 -: RAW];

  // Stores carry two source registers in A/B and write nothing back.
  always_comb begin
    dec_rs1  = fld_b;
    dec_rs2  = fld_c;
    dec_dest = fld_a;
    dec_we   = 1'b1;
    if (dec_op == STORE_OP) begin
      dec_rs1  = fld_a;
      dec_rs2  = fld_b;
      dec_dest = '0;
      dec_we   = 1'b0;
    end
  end

  assign out_valid = (state == FULL);
  assign drain     = out_valid & out_ready;
  assign slot_free = (state != FULL) | drain;
  assign in_ready  = ~flush & ~hazard & slot_free;
  assign accept    = in_valid & in_ready;

`ifdef DECODE_INTERLOCK_EN
  logic           load_pend;
  logic [RAW-1:0] ld_dest;
  logic [7:0]     stall_q;

  assign hazard      = load_pend & ((ld_dest == dec_rs1) | (ld_dest == dec_rs2));
  assign bubble      = ~flush & in_valid & hazard & slot_free;
  assign stall_count = stall_q;

  // Remember the destination of the instruction just issued if it was a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_pend <= 1'b0;
      ld_dest   <= '0;
      stall_q   <= '0;
    end else begin
      if (flush || bubble) begin
        load_pend <= 1'b0;
      end else if (accept) begin
        load_pend <= (dec_op == LOAD_OP);
        ld_dest   <= fld_a;
      end
      if (bubble && stall_q != 8'hFF)
        stall_q <= stall_q + 8'd1;
    end
  end
`else
  logic unused_load;

  assign unused_load = (dec_op == LOAD_OP);
  assign hazard      = 1'b0;
  assign bubble      = 1'b0;
  assign stall_count = '0;
`endif

  // Output register and occupancy; a bubble slot behaves like an empty one for intake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= EMPTY;
      out_opcode     <= '0;
      ReadAddressRF1 <= '0;
      ReadAddressRF2 <= '0;
      out_dest       <= '0;
      out_we         <= 1'b0;
    end else begin
      if (accept) begin
        out_opcode     <= dec_op;
        ReadAddressRF1 <= dec_rs1;
        ReadAddressRF2 <= dec_rs2;
        out_dest       <= dec_dest;
        out_we         <= dec_we;
      end
      if (flush)
        state <= EMPTY;
      else if (accept)
        state <= FULL;
      else if (bubble)
        state <= BUBBLE;
      else if (state == BUBBLE || drain)
        state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed steps followed by randomized traffic,
// compared against a transaction-level model of the stage.
module tb_instruction_decode_stage;

  localparam int IW = 20;
  localparam int STORE = 12;
  localparam int LOAD  = 11;
`ifdef DECODE_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, flush, out_valid, out_ready, out_we;
  logic [IW-1:0] instruction;
  logic [3:0]    out_opcode, ReadAddressRF1, ReadAddressRF2, out_dest;
  logic [7:0]    stall_count;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  bit m_full, m_pend, m_we;
  int m_op, m_rs1, m_rs2, m_dest, m_ld, m_stall;

  instruction_decode_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .ReadAddressRF1(ReadAddressRF1),
    .ReadAddressRF2(ReadAddressRF2), .out_dest(out_dest),
    .out_we(out_we), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void refDecode(input int inst, output int op, output int a,
                                    output int rs1, output int rs2, output int dest,
                                    output bit we);
    int fb, fc;
    op = (inst >> 16) & 15;
    a  = (inst >> 12) & 15;
    fb = (inst >> 8) & 15;
    fc = (inst >> 4) & 15;
    if (op == STORE) begin
      rs1 = a; rs2 = fb; dest = 0; we = 1'b0;
    end else begin
      rs1 = fb; rs2 = fc; dest = a; we = 1'b1;
    end
  endfunction

  task automatic modelReset();
    m_full = 0; m_pend = 0; m_we = 0;
    m_op = 0; m_rs1 = 0; m_rs2 = 0; m_dest = 0; m_ld = 0; m_stall = 0;
  endtask

  task automatic checkOutput();
    check("out_valid", out_valid, m_full);
    check("out_opcode", out_opcode, m_op);
    check("rf1", ReadAddressRF1, m_rs1);
    check("rf2", ReadAddressRF2, m_rs2);
    check("out_dest", out_dest, m_dest);
    check("out_we", out_we, m_we);
    check("stall_count", stall_count, m_stall);
  endtask

  // One clock of traffic: drive, check ready, advance the model, then check the outputs.
  task automatic applyStimulus(input bit v, input int inst, input bit fl, input bit ordy,
                               output bit took);
    int op, a, rs1, rs2, dest;
    bit we, haz, room, rdy;
    in_valid = v; instruction = inst[IW-1:0]; flush = fl; out_ready = ordy;
    refDecode(inst, op, a, rs1, rs2, dest, we);
    haz  = INTERLOCK && m_pend && (m_ld == rs1 || m_ld == rs2);
    room = !m_full || ordy;
    rdy  = !fl && !haz && room;
    #1;
    check("in_ready", in_ready, rdy);
    took = v && in_ready;
    if (fl) begin
      m_full = 0; m_pend = 0;
    end else if (v && rdy) begin
      m_full = 1; m_op = op; m_rs1 = rs1; m_rs2 = rs2; m_dest = dest; m_we = we;
      m_pend = (op == LOAD); m_ld = a;
    end else if (v && haz && room) begin
      m_full = 0; m_pend = 0;
      if (m_stall < 255) m_stall++;
    end else if (ordy) begin
      m_full = 0;
    end
    @(posedge clock); #1;
    checkOutput();
  endtask

  task automatic sendUntilTaken(input int inst, output int tries);
    bit took;
    tries = 0;
    do begin
      applyStimulus(1'b1, inst, 1'b0, 1'b1, took);
      tries++;
    end while (!took && tries < 6);
  endtask

  initial begin
    bit took;
    int tries, st0, op, rn;
    reset = 1'b1; in_valid = 0; instruction = '0; flush = 0; out_ready = 0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput();
    reset = 1'b0;

    // Field extraction and the store swap
    applyStimulus(1'b1, 'h13570, 1'b0, 1'b1, took);
    check("swap_dest", out_dest, 3);
    check("swap_rf1", ReadAddressRF1, 5);
    check("swap_rf2", ReadAddressRF2, 7);
    check("swap_we", out_we, 1);
    applyStimulus(1'b1, 'hC3570, 1'b0, 1'b1, took);
    check("store_rf1", ReadAddressRF1, 3);
    check("store_rf2", ReadAddressRF2, 5);
    check("store_dest", out_dest, 0);
    check("store_we", out_we, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, took);

    // Backpressure holds the output register and blocks intake
    applyStimulus(1'b1, 'h21230, 1'b0, 1'b1, took);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 'h34560, 1'b0, 1'b0, took);
    check("bp_held_op", out_opcode, 2);
    applyStimulus(1'b1, 'h34560, 1'b0, 1'b1, took);
    check("bp_next_op", out_opcode, 3);
    check("bp_next_valid", out_valid, 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, took);

    // Load-use dependency, then an independent follower
    st0 = m_stall;
    applyStimulus(1'b1, 'hB4000, 1'b0, 1'b1, took);
    sendUntilTaken('h12400, tries);
    check("loaduse_tries", tries, INTERLOCK ? 2 : 1);
    check("loaduse_stall", stall_count, st0 + (INTERLOCK ? 1 : 0));
    applyStimulus(1'b0, 0, 1'b0, 1'b1, took);
    applyStimulus(1'b1, 'hB4000, 1'b0, 1'b1, took);
    sendUntilTaken('h12500, tries);
    check("indep_tries", tries, 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, took);

    // Flush drops the incoming word and cancels a pending load
    applyStimulus(1'b1, 'hB4000, 1'b0, 1'b1, took);
    applyStimulus(1'b1, 'h51110, 1'b1, 1'b0, took);
    check("flush_valid", out_valid, 0);
    sendUntilTaken('h12400, tries);
    check("flush_clears_pend", tries, 1);

    // Randomized traffic with a mid-stream reset
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        reset = 1'b1;
        #1;
        modelReset();
        check("midrst_valid", out_valid, 0);
        check("midrst_stall", stall_count, 0);
        checkOutput();
        @(posedge clock); #1;
        reset = 1'b0;
      end
      rn = $urandom_range(0, 3);
      op = (rn == 0) ? LOAD : (rn == 1) ? STORE : $urandom_range(0, 15);
      applyStimulus($urandom_range(0, 3) != 0,
                    (op << 16) | ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 8)
                      | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, took);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
